text_line_renderer: RTL and testbench

Pixel-pipeline stage directly downstream of the 80-column character ROM: it drives the ROM column address from the VGA timing generator's beam position and consumes the returned ASCII code. It looks the code up in an external 8x16 font ROM and serialises the glyph row into a 1-bit pixel stream. Syncs and display enable are delayed to stay aligned with the pixels. It renders one 16-scanline text band of 80 characters at a fixed vertical offset on a 640x480 display.

---
 rtl/text_pkg.sv | 32 +++
 rtl/sig_delay.sv | 25 ++
 rtl/text_line_renderer.sv | 104 ++++++++++
 tb/tb_text_line_renderer.sv | 168 ++++++++++++++++
 4 files changed

// File: rtl/text_pkg.sv
// text_pkg: shared constants and pipeline bundle types for the text band renderer.
// The cursor column only rides the side-band pipeline when TEXT_CURSOR_EN is defined.
package text_pkg;

    localparam int CHAR_W      = 8;
    localparam int CHAR_H      = 16;
    localparam int TEXT_COLS   = 80;
    localparam int TEXT_LAT    = 6;
    localparam int BLINK_BITS  = 5;
    localparam int CURSOR_ROW0 = 14;

    typedef struct packed {
`ifdef TEXT_CURSOR_EN
        logic [6:0] col;
`endif
        logic [2:0] xbit;
        logic [3:0] row;
        logic       in_band;
        logic       de;
    } side_t;

    typedef struct packed {
        logic hsync;
        logic vsync;
        logic de;
    } sync_t;

    function automatic logic in_cursor_rows(input logic [3:0] row);
        return row >= 4'(CURSOR_ROW0);
    endfunction

endpackage

// File: rtl/sig_delay.sv
// sig_delay: fixed-depth shift-register delay with synchronous active-low clear.
module sig_delay #(
    parameter int WIDTH = 1,
    parameter int DEPTH = 1
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic [WIDTH-1:0] din_i,
    output logic [WIDTH-1:0] dout_o
);

    logic [WIDTH-1:0] pipe_q [DEPTH];

    always_ff @(posedge clk) begin
        if (!resetn) begin
            for (int i = 0; i < DEPTH; i++) pipe_q[i] <= '0;
        end else begin
            pipe_q[0] <= din_i;
            for (int i = 1; i < DEPTH; i++) pipe_q[i] <= pipe_q[i-1];
        end
    end

    assign dout_o = pipe_q[DEPTH-1];

endmodule

// File: rtl/text_line_renderer.sv
// text_line_renderer: fetches 80 characters of one text band and serialises glyph rows into pixels.
// TEXT_CURSOR_EN adds a blinking underline cursor at cursor_col.
module text_line_renderer
    import text_pkg::*;
#(
    parameter int TEXT_Y0 = 232
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic [9:0]  hpos,
    input  logic [9:0]  vpos,
    input  logic        de,
    input  logic        hsync,
    input  logic        vsync,
    output logic [6:0]  char_addr,
    input  logic [6:0]  char_code,
    output logic [10:0] font_addr,
    input  logic [7:0]  font_row,
    output logic        pix_out,
    output logic        de_out,
    output logic        hsync_out,
    output logic        vsync_out
`ifdef TEXT_CURSOR_EN
    ,
    input  logic [6:0]  cursor_col
`endif
);

    side_t       side_in, side_s2, side_s4;
    sync_t       sync_in, sync_out;
    logic [6:0]  char_addr_q;
    logic [10:0] font_addr_q;
    logic        pix_q, pix_d;
    logic        cursor_hit;

    always_comb begin
        side_in         = '0;
        side_in.xbit    = hpos[2:0];
        side_in.row     = 4'(vpos - 10'(TEXT_Y0));
        side_in.in_band = (vpos >= 10'(TEXT_Y0)) && (vpos < 10'(TEXT_Y0 + CHAR_H));
        side_in.de      = de;
`ifdef TEXT_CURSOR_EN
        side_in.col     = hpos[9:3];
`endif
    end

    // Split at stage 2 so the glyph row is available when font_addr is formed.
    sig_delay #(.WIDTH($bits(side_t)), .DEPTH(3)) u_side_a (
        .clk    (clk),
        .resetn (resetn),
        .din_i  (side_in),
        .dout_o (side_s2)
    );

    sig_delay #(.WIDTH($bits(side_t)), .DEPTH(2)) u_side_b (
        .clk    (clk),
        .resetn (resetn),
        .din_i  (side_s2),
        .dout_o (side_s4)
    );

    assign sync_in = '{hsync: hsync, vsync: vsync, de: de};

    sig_delay #(.WIDTH($bits(sync_t)), .DEPTH(TEXT_LAT)) u_sync (
        .clk    (clk),
        .resetn (resetn),
        .din_i  (sync_in),
        .dout_o (sync_out)
    );

`ifdef TEXT_CURSOR_EN
    logic [BLINK_BITS-1:0] blink_q, blink_d;
    assign blink_d    = (vpos == 10'd480 && hpos == 10'd0) ? blink_q + 1'b1 : blink_q;
    assign cursor_hit = blink_q[BLINK_BITS-1] && side_s4.col == cursor_col && in_cursor_rows(side_s4.row);
    always_ff @(posedge clk) begin
        if (!resetn) blink_q <= '0;
        else         blink_q <= blink_d;
    end
`else
    assign cursor_hit = 1'b0;
`endif

    assign pix_d = (font_row[3'd7 - side_s4.xbit] ^ cursor_hit) & side_s4.in_band & side_s4.de;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            char_addr_q <= '0;
            font_addr_q <= '0;
            pix_q       <= 1'b0;
        end else begin
            char_addr_q <= hpos[9:3];
            font_addr_q <= {char_code, side_s2.row};
            pix_q       <= pix_d;
        end
    end

    assign char_addr = char_addr_q;
    assign font_addr = font_addr_q;
    assign pix_out   = pix_q;
    assign de_out    = sync_out.de;
    assign hsync_out = sync_out.hsync;
    assign vsync_out = sync_out.vsync;

endmodule

// File: tb/tb_text_line_renderer.sv
// tb_text_line_renderer: directed checks of latency, glyph fetch, band edges, wrap and cursor blink.
module tb_text_line_renderer;

`ifdef TEXT_CURSOR_EN
    localparam bit CUR = 1'b1;
`else
    localparam bit CUR = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic [9:0]  hpos = '0, vpos = '0;
    logic        de = 1'b0, hsync = 1'b0, vsync = 1'b0;
    logic [6:0]  char_addr, char_code;
    logic [10:0] font_addr;
    logic [7:0]  font_row;
    logic        pix_out, de_out, hsync_out, vsync_out;
    logic [7:0]  font_val = 8'h00;
    logic [6:0]  rom_a_q;
`ifdef TEXT_CURSOR_EN
    logic [6:0]  cursor_col = 7'd5;
`endif

    int checks = 0;
    int errors = 0;
    logic [9:0] hq[$];
    logic       dq[$], hsq[$], vsq[$];

    always #5 clk = ~clk;

    text_line_renderer dut (
        .clk       (clk),
        .resetn    (resetn),
        .hpos      (hpos),
        .vpos      (vpos),
        .de        (de),
        .hsync     (hsync),
        .vsync     (vsync),
        .char_addr (char_addr),
        .char_code (char_code),
        .font_addr (font_addr),
        .font_row  (font_row),
        .pix_out   (pix_out),
        .de_out    (de_out),
        .hsync_out (hsync_out),
        .vsync_out (vsync_out)
`ifdef TEXT_CURSOR_EN
        ,
        .cursor_col(cursor_col)
`endif
    );

    function automatic logic [6:0] char_rom(input logic [6:0] a);
        if (a == 7'd1) return 7'd104;
        if (a >= 7'd80) return 7'd0;
        return a;
    endfunction

    always_ff @(posedge clk) begin
        rom_a_q   <= char_addr;
        char_code <= char_rom(rom_a_q);
        font_row  <= (font_addr == 11'h683) ? 8'hA5 : font_val;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic [9:0] h, input logic [9:0] v, input logic d, input logic hs, input logic vs);
        hpos = h; vpos = v; de = d; hsync = hs; vsync = vs;
        hq.push_back(h); dq.push_back(d); hsq.push_back(hs); vsq.push_back(vs);
        @(posedge clk);
        #1;
    endtask

    initial begin
        int sz;
        int hv;
        logic [31:0] dp, hp, vp;
        logic [7:0]  pat;
        logic [9:0]  bv [4];
        logic        be [4];
        // reset with active inputs
        resetn = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step(10'd0, 10'd0, 1'b1, 1'b1, 1'b1);
            chk("rst_de", de_out, 0);
            chk("rst_hs", hsync_out, 0);
            chk("rst_vs", vsync_out, 0);
            chk("rst_pix", pix_out, 0);
            chk("rst_caddr", char_addr, 0);
            chk("rst_faddr", font_addr, 0);
        end
        resetn = 1'b1;
        for (int i = 0; i < 6; i++) begin
            step(10'd0, 10'd0, 1'b1, 1'b1, 1'b0);
            chk("rel_de", de_out, (i == 5) ? 1 : 0);
            chk("rel_hs", hsync_out, (i == 5) ? 1 : 0);
        end
        // glyph fetch: char 1 -> code 104, row 3
        font_val = 8'h00;
        pat = 8'hA5;
        for (int i = 0; i < 14; i++) begin
            step(10'(8 + i), 10'd235, 1'b1, 1'b0, 1'b0);
            chk("glyph_caddr", char_addr, 32'((8 + i) >> 3));
            if (i >= 3 && i <= 10) chk("glyph_faddr", font_addr, 32'h683);
            if (i >= 5 && i <= 12) chk("glyph_pix", pix_out, 32'(pat[12 - i]));
            if (i == 13) chk("glyph_next", pix_out, 0);
        end
        // band edges
        font_val = 8'hFF;
        bv[0] = 10'd231; be[0] = 1'b0;
        bv[1] = 10'd232; be[1] = 1'b1;
        bv[2] = 10'd247; be[2] = 1'b1;
        bv[3] = 10'd248; be[3] = 1'b0;
        for (int b = 0; b < 4; b++) begin
            for (int i = 0; i < 6; i++) step(10'd100, bv[b], 1'b1, 1'b0, 1'b0);
            chk("band_pix", pix_out, 32'(be[b]));
        end
        // blanking / alignment with directed patterns, in band, solid font
        dp = 32'hF0F3_1C65;
        hp = 32'h9A3C_5E21;
        vp = 32'h3C96_0F4B;
        for (int i = 0; i < 32; i++) begin
            step(10'd100, 10'd240, dp[i], hp[i], vp[i]);
            sz = dq.size();
            if (i >= 5) begin
                chk("align_de", de_out, 32'(dq[sz-6]));
                chk("align_hs", hsync_out, 32'(hsq[sz-6]));
                chk("align_vs", vsync_out, 32'(vsq[sz-6]));
                chk("align_pix", pix_out, 32'(dq[sz-6]));
            end
        end
        // line wrap 632..799, 0..15
        for (int i = 0; i < 184; i++) begin
            hv = (632 + i) % 800;
            step(10'(hv), 10'd240, hv < 640, 1'b0, 1'b0);
            sz = hq.size();
            chk("wrap_caddr", char_addr, 32'(hv >> 3));
            if (i >= 5) chk("wrap_pix", pix_out, 32'(hq[sz-6] < 10'd640));
        end
        // cursor blink
        resetn = 1'b0;
        step(10'd0, 10'd0, 1'b0, 1'b0, 1'b0);
        chk("mid_rst_de", de_out, 0);
        resetn = 1'b1;
        font_val = 8'h00;
        for (int i = 0; i < 16; i++) step(10'd0, 10'd480, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 16; i++) begin
            step(10'(40 + i), 10'd246, 1'b1, 1'b0, 1'b0);
            if (i >= 5) chk("cur_on_r14", pix_out, (i - 5 < 8) ? 32'(CUR) : 0);
        end
        for (int i = 0; i < 6; i++) step(10'd44, 10'd245, 1'b1, 1'b0, 1'b0);
        chk("cur_r13", pix_out, 0);
        for (int i = 0; i < 6; i++) step(10'd44, 10'd247, 1'b1, 1'b0, 1'b0);
        chk("cur_on_r15", pix_out, 32'(CUR));
        for (int i = 0; i < 16; i++) step(10'd0, 10'd480, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 6; i++) step(10'd44, 10'd247, 1'b1, 1'b0, 1'b0);
        chk("cur_off_32", pix_out, 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
